// File: rtl/mxu_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mxu_controller
//  Description : Job sequencer for a weight-stationary MXU wrapper. Loads M
//                weight rows, streams num_vectors input vectors, tracks which
//                pipeline slots hold real results, and drains the pipeline
//                before signalling completion.
//
//  Ports
//    clk, reset          : clock, synchronous active-high reset
//    start               : job request (sampled in IDLE only)
//    num_vectors         : job length, captured with start
//    data_type_in        : precision code, captured with start
//    weight_valid/ready  : weight-row handshake (LOAD_W only)
//    in_valid/in_ready   : input-vector handshake (STREAM only)
//    out_valid/out_ready : result handshake
//    data_type           : captured precision code driven to the MXU
//    enable*             : MXU wrapper enables
//    busy                : high whenever a job is in flight
//    done                : one-cycle completion pulse
//
//  Revision    : 1.0  initial release
// ============================================================================
module mxu_controller #(
    parameter int M                      = 3,
    parameter int K                      = 3,
    parameter int CORE_LAT               = 3,
    parameter int CNT_W                  = 16,
    parameter int LOG_ALLOWED_PRECISIONS = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [CNT_W-1:0]                  num_vectors,
    input  logic [LOG_ALLOWED_PRECISIONS-1:0] data_type_in,
    input  logic                              weight_valid,
    output logic                              weight_ready,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              out_ready,
    output logic                              out_valid,
    output logic [LOG_ALLOWED_PRECISIONS-1:0] data_type,
    output logic                              enable,
    output logic                              enable_in_ff,
    output logic                              enable_chain,
    output logic                              enable_out_ff,
    output logic                              busy,
    output logic                              done
);

    // Number of advance cycles between accepting a vector and its result
    // appearing: input skew across K lanes, core latency, output de-skew
    // across M lanes.
    localparam int PIPE   = (K - 1) + CORE_LAT + (M - 1);
    localparam int WCNT_W = $clog2(M + 1);

    localparam logic [WCNT_W-1:0] c_WCNT_LAST = WCNT_W'(M - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_W = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]                        r_state;
    logic [CNT_W-1:0]                  r_vcnt;
    logic [WCNT_W-1:0]                 r_wcnt;
    logic [CNT_W-1:0]                  r_num;
    logic [LOG_ALLOWED_PRECISIONS-1:0] r_data_type;
    logic [PIPE-1:0]                   r_vld;

    logic [2:0]                        w_state_d;
    logic [CNT_W-1:0]                  w_vcnt_d;
    logic [WCNT_W-1:0]                 w_wcnt_d;
    logic [CNT_W-1:0]                  w_num_d;
    logic [LOG_ALLOWED_PRECISIONS-1:0] w_data_type_d;
    logic [PIPE-1:0]                   w_vld_d;
    logic [PIPE-1:0]                   w_vld_shift;

    logic                              w_in_load;
    logic                              w_in_stream;
    logic                              w_in_drain;
    logic                              w_adv;
    logic                              w_w_acc;
    logic                              w_v_acc;
    logic [CNT_W-1:0]                  w_vcnt_inc;

    // ------------------------------------------------------------------
    // Handshakes and enables
    // ------------------------------------------------------------------
    assign w_in_load   = (r_state == S_LOAD_W);
    assign w_in_stream = (r_state == S_STREAM);
    assign w_in_drain  = (r_state == S_DRAIN);

    // The whole MXU pipeline moves only when the sink can take a result,
    // so a stalled sink freezes every stage and no result is lost.
    assign w_adv   = (w_in_stream || w_in_drain) && out_ready;

    assign w_w_acc = w_in_load && weight_valid;
    assign w_v_acc = w_in_stream && out_ready && in_valid;

    assign weight_ready  = w_in_load;
    assign enable_chain  = w_w_acc;
    assign in_ready      = w_in_stream && out_ready;
    assign enable        = w_adv;
    assign enable_in_ff  = w_adv;
    assign enable_out_ff = w_adv;

    assign out_valid = r_vld[PIPE-1];
    assign data_type = r_data_type;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

    assign w_vcnt_inc = r_vcnt + CNT_W'(1);

    // ------------------------------------------------------------------
    // Valid-tracking shift register: one bit per pipeline slot, set for
    // slots carrying a real vector and clear for bubbles.
    // ------------------------------------------------------------------
    always_comb begin
        w_vld_shift[0] = w_v_acc;
        for (int i = 1; i < PIPE; i++) begin
            w_vld_shift[i] = r_vld[i-1];
        end
        w_vld_d = w_adv ? w_vld_shift : r_vld;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d     = r_state;
        w_vcnt_d      = r_vcnt;
        w_wcnt_d      = r_wcnt;
        w_num_d       = r_num;
        w_data_type_d = r_data_type;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_num_d       = num_vectors;
                    w_data_type_d = data_type_in;
                    w_vcnt_d      = '0;
                    w_wcnt_d      = '0;
                    w_state_d     = S_LOAD_W;
                end
            end

            S_LOAD_W: begin
                if (w_w_acc) begin
                    w_wcnt_d = r_wcnt + WCNT_W'(1);
                    if (r_wcnt == c_WCNT_LAST) begin
                        // An empty job still loads weights but streams nothing.
                        w_state_d = (r_num == '0) ? S_DONE : S_STREAM;
                    end
                end
            end

            S_STREAM: begin
                if (w_v_acc) begin
                    w_vcnt_d = w_vcnt_inc;
                    if (w_vcnt_inc == r_num) begin
                        w_state_d = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                // Finish only once no slot holds an undelivered result.
                if (r_vld == '0) begin
                    w_state_d = S_DONE;
                end
            end

            S_DONE: begin
                w_state_d = S_IDLE;
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_vcnt      <= '0;
            r_wcnt      <= '0;
            r_num       <= '0;
            r_data_type <= '0;
            r_vld       <= '0;
        end else begin
            r_state     <= w_state_d;
            r_vcnt      <= w_vcnt_d;
            r_wcnt      <= w_wcnt_d;
            r_num       <= w_num_d;
            r_data_type <= w_data_type_d;
            r_vld       <= w_vld_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/mxu_controller.md
MXU_CONTROLLER -- requirements
Module: mxu_controller

Interface
REQ-001 Parameter M, default 3, MXU rows (weight rows/output lanes).
REQ-002 Parameter K, default 3, MXU columns (input lanes).
REQ-003 Parameter CORE_LAT, default 3, mxu_core input-to-output latency in cycles.
REQ-004 Parameter CNT_W, default 16, vector counter width.
REQ-005 Ports, one per line; clk and reset first:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request job; sampled only in IDLE.
- num_vectors  in  CNT_W  input vectors in job; sampled with start.
- data_type_in  in  LOG_ALLOWED_PRECISIONS  precision code (precision_def.vh); sampled with start.
- weight_valid  in  1  weight row present.
- weight_ready  out  1  weight row accepted when weight_valid && weight_ready.
- in_valid  in  1  input vector present.
- in_ready  out  1  input vector accepted when in_valid && in_ready.
- out_ready  in  1  sink can take result.
- out_valid  out  1  mxu y holds a valid result.
- data_type  out  LOG_ALLOWED_PRECISIONS  latched precision to MXU.
- enable, enable_in_ff, enable_chain, enable_out_ff  out  1 each  MXU wrapper enables.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle job-complete pulse.

Function
REQ-006 FSM states IDLE, LOAD_W, STREAM, DRAIN, DONE; encoding free.
REQ-007 IDLE: start=1 latches num_vectors and data_type_in, clears counters, goes to LOAD_W; start outside IDLE is ignored.
REQ-008 LOAD_W: weight_ready=1; each accepted beat pulses enable_chain=1 that cycle and increments wcnt; after M accepted beats goes to STREAM, or to DONE if latched num_vectors=0.
REQ-009 enable_chain is 0 in every state except on accepted LOAD_W beats.
REQ-010 Advance signal adv = out_ready in STREAM and DRAIN, else 0.
REQ-011 enable = enable_in_ff = enable_out_ff = adv; a cycle with out_ready=0 freezes the whole MXU pipeline.
REQ-012 STREAM: in_ready = out_ready; accepted vector increments vcnt; adv cycle with in_valid=0 inserts a bubble.
REQ-013 Valid-tracking shift register depth PIPE = (K-1)+CORE_LAT+(M-1) shifts only on adv; input bit = accepted-vector flag (0 in DRAIN).
REQ-014 out_valid = last stage of tracking register; held constant while out_ready=0.
REQ-015 Result transfers on out_valid && out_ready; each accepted vector yields exactly one result, in order, PIPE adv cycles after acceptance.
REQ-016 STREAM -> DRAIN on the cycle vcnt reaches latched num_vectors (that acceptance included).
REQ-017 DRAIN: in_ready=0; goes to DONE in the cycle after tracking register becomes all-zero.
REQ-018 DONE: done=1 for exactly one cycle, then IDLE; start in DONE is ignored.
REQ-019 data_type holds latched value from start until next accepted start.
REQ-020 vcnt and wcnt are CNT_W and clog2(M+1) bits; no wrap within a job since num_vectors <= 2^CNT_W-1.

Reset
REQ-021 reset=1 at any clock edge, including mid-job, forces IDLE, clears tracking register, vcnt, wcnt, data_type; reset takes priority over all inputs.
REQ-022 Outputs during/after reset: weight_ready, in_ready, out_valid, enable, enable_in_ff, enable_chain, enable_out_ff, busy, done all 0; data_type 0.

Verification (M=3, K=3, CORE_LAT=3, PIPE=7)
REQ-023 start, num_vectors=4, weight_valid/in_valid/out_ready held 1 -> 3 enable_chain pulses, 4 in_ready handshakes, out_valid high exactly 4 cycles starting 7 cycles after first acceptance, done pulse once, busy drops next cycle.
REQ-024 num_vectors=0 -> 3 weight beats, then DONE, in_ready never 1, out_valid never 1.
REQ-025 num_vectors=5, out_ready low 3 cycles mid-stream -> enable/enable_in_ff/enable_out_ff 0 for those cycles, out_valid stable, all 5 results delivered in order, none duplicated.
REQ-026 num_vectors=3, in_valid deasserted 2 cycles between vectors 1 and 2 -> result 2 gap of 2 cycles at output, total 3 out_valid beats.
REQ-027 reset pulsed in STREAM after 2 acceptances -> next cycle IDLE, all outputs per REQ-022; new start runs a full job correctly.
REQ-028 start asserted during STREAM with different num_vectors/data_type_in -> ignored; data_type and job length unchanged.
